// File: rtl/urcpu_pkg.sv
// urcpu_pkg: shared URCPU widths, reset PC and fetch FSM state encoding
package urcpu_pkg;
  localparam int ADDR_W = 20;
  localparam int INSTR_W = 20;
  localparam logic [ADDR_W-1:0] RESET_PC = 20'h00000;
  typedef enum logic [1:0] {FETCH_IDLE, FETCH_REQ, FETCH_HOLD, FETCH_DRAIN} fetch_state_t;
endpackage

// File: rtl/increment_module.sv
// increment_module: 20-bit PC incrementer, wraps 20'hFFFFF -> 20'h00000 with no carry out
// Ports: in (current PC), out (in + 1).
module increment_module (
  input  logic [19:0] in,
  output logic [19:0] out
);
  assign out = in + 20'd1;
endmodule

// File: rtl/pc_fetch.sv
// pc_fetch: URCPU program counter and single-outstanding instruction fetch stage
// Ports: clk/rst (async active-high); redirect_valid/redirect_pc from execute;
// imem_req/imem_addr/imem_ack/imem_rdata to instruction memory;
// instr_valid/instr_ready/instr_data/instr_pc to decode;
// perf_fetch_cnt (accepted-instruction count) only when URCPU_PERF_CNT_EN is defined.
module pc_fetch import urcpu_pkg::*; #(
  parameter int ADDR_W = urcpu_pkg::ADDR_W,
  parameter int INSTR_W = urcpu_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = urcpu_pkg::RESET_PC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_data,
  output logic [ADDR_W-1:0]  instr_pc
`ifdef URCPU_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetch_cnt
`endif
);
  fetch_state_t state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, pc_plus1;
  logic ack, hs, valid_n, load;
  increment_module u_inc (.in(pc), .out(pc_plus1));
  // an ack only counts while a request is actually outstanding
  assign ack = imem_req & imem_ack;
  assign hs = instr_valid & instr_ready;
  // capture fetched word only for an unflushed ack
  assign load = (state == FETCH_REQ) & ack & !redirect_valid;
  always_comb begin
    state_n = state;
    pc_n = redirect_valid ? redirect_pc : pc;
    valid_n = instr_valid & !redirect_valid;
    case (state)
      FETCH_IDLE: state_n = FETCH_REQ;
      FETCH_REQ: begin
        state_n = ack ? (redirect_valid ? FETCH_REQ : FETCH_HOLD) : (redirect_valid ? FETCH_DRAIN : FETCH_REQ);
        pc_n = redirect_valid ? redirect_pc : (ack ? pc_plus1 : pc);
        valid_n = load;
      end
      FETCH_HOLD: begin
        state_n = (hs || redirect_valid) ? FETCH_REQ : FETCH_HOLD;
        valid_n = !hs && !redirect_valid;
      end
      FETCH_DRAIN: state_n = ack ? FETCH_REQ : FETCH_DRAIN;
      default: state_n = FETCH_IDLE;
    endcase
  end
  // a drained request keeps its pre-redirect address until acked
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH_IDLE;
      pc <= RESET_PC;
      imem_req <= 1'b0;
      imem_addr <= RESET_PC;
      instr_valid <= 1'b0;
      instr_data <= '0;
      instr_pc <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      imem_req <= (state_n == FETCH_REQ) || (state_n == FETCH_DRAIN);
      imem_addr <= (state_n == FETCH_REQ) ? pc_n : imem_addr;
      instr_valid <= valid_n;
      if (load) begin
        instr_data <= imem_rdata;
        instr_pc <= pc;
      end
    end
  end
`ifdef URCPU_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) perf_fetch_cnt <= '0;
    else if (hs) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: randomized scoreboard bench for pc_fetch against an instruction-stream model
module tb_pc_fetch;
  logic clk = 0, rst = 1, redirect_valid = 0, imem_ack = 0, instr_ready = 0;
  logic imem_req, instr_valid;
  logic [19:0] redirect_pc = 0, imem_addr, imem_rdata, instr_data, instr_pc;
`ifdef URCPU_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
`endif
  int checks = 0, errors = 0, idle = 0, hs_cnt = 0;
  int unsigned ack_p = 100, rdy_p = 100, red_p = 0;
  logic [19:0] exp_q[$];
  logic [19:0] e_pc, p_addr, p_pc, p_data, held, rec_pc, rec_data;
  logic p_req = 0, p_ack = 0, p_val = 0, p_rdy = 0, p_red = 0;

  pc_fetch dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data), .instr_pc(instr_pc)
`ifdef URCPU_PERF_CNT_EN
    , .perf_fetch_cnt(perf_fetch_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] mem(input logic [19:0] a);
    return {a[6:0], a[19:7]} ^ 20'h5A3C9;
  endfunction
  assign imem_rdata = mem(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    imem_ack = $urandom_range(99) < ack_p;
    instr_ready = $urandom_range(99) < rdy_p;
    redirect_valid = $urandom_range(99) < red_p;
    redirect_pc = ($urandom_range(3) == 0) ? 20'hFFFFD + 20'($urandom_range(3)) : 20'($urandom);
  endtask

  task automatic wait_for(input bit v);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!(v ? instr_valid : imem_req) && n < 40);
    chk(v ? "wait_valid" : "wait_req", 32'(v ? instr_valid : imem_req), 32'd1);
  endtask

  // model: decode sees consecutive PCs from the last redirect target (or reset PC);
  // a word accepted on the same cycle as a redirect still counts, unaccepted words are dropped
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_q.push_back(20'h00000);
      p_req = 0;
      p_val = 0;
      idle = 0;
      hs_cnt = 0;
    end else begin
      if (p_req && !p_ack) chk("req_hold", 32'({imem_req, imem_addr}), 32'({1'b1, p_addr}));
      if (p_val && !p_rdy && p_red) chk("flush", 32'(instr_valid), 32'd0);
      if (p_val && !p_rdy && !p_red) begin
        chk("out_hold", 32'({instr_valid, instr_pc}), 32'({1'b1, p_pc}));
        chk("out_hold_data", 32'(instr_data), 32'(p_data));
      end
      if (p_val && p_rdy) chk("no_skid", 32'(instr_valid), 32'd0);
      if (instr_valid && imem_req) chk("req_while_valid", 32'(imem_req), 32'd0);
      if (instr_valid && instr_ready) begin
        chk("sb_size", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() > 0) begin
          e_pc = exp_q.pop_front();
          chk("instr_pc", 32'(instr_pc), 32'(e_pc));
          chk("instr_data", 32'(instr_data), 32'(mem(e_pc)));
          exp_q.push_back(e_pc + 20'd1);
        end
        hs_cnt++;
        idle = 0;
      end else if (++idle > 200) begin
        chk("watchdog", 32'(idle), 32'd0);
        idle = 0;
      end
      if (redirect_valid) begin
        exp_q.delete();
        exp_q.push_back(redirect_pc);
      end
      {p_req, p_ack, p_val, p_rdy, p_red} = {imem_req, imem_ack, instr_valid, instr_ready, redirect_valid};
      {p_addr, p_pc, p_data} = {imem_addr, instr_pc, instr_data};
    end
  end

  initial begin
    repeat (3) tick();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_data", 32'(instr_data), 32'd0);
    chk("rst_pc", 32'(instr_pc), 32'd0);
    rst = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("t1_req", 32'(imem_req), 32'(k % 2));
      if (k % 2 == 1) chk("t1_addr", 32'(imem_addr), 32'((k - 1) / 2));
      else begin
        chk("t1_valid", 32'(instr_valid), 32'd1);
        chk("t1_pc", 32'(instr_pc), 32'(k / 2 - 1));
        chk("t1_data", 32'(instr_data), 32'(mem(20'(k / 2 - 1))));
      end
    end
    rdy_p = 0;
    instr_ready = 0;
    rec_pc = instr_pc;
    rec_data = instr_data;
    repeat (5) begin
      tick();
      chk("t2_stall", 32'({instr_valid, imem_req, instr_pc}), 32'({1'b1, 1'b0, rec_pc}));
      chk("t2_data", 32'(instr_data), 32'(rec_data));
    end
    rdy_p = 100;
    tick();
    wait_for(0);
    chk("t2_next_addr", 32'(imem_addr), 32'(rec_pc + 20'd1));
    ack_p = 0;
    imem_ack = 0;
    held = imem_addr;
    redirect_valid = 1;
    redirect_pc = 20'h00400;
    tick();
    repeat (3) begin
      chk("t3_drain_hold", 32'({imem_req, imem_addr}), 32'({1'b1, held}));
      tick();
    end
    ack_p = 100;
    imem_ack = 1;
    tick();
    chk("t3_new_addr", 32'({imem_req, imem_addr}), 32'({1'b1, 20'h00400}));
    wait_for(1);
    chk("t3_pc", 32'(instr_pc), 32'h00400);
    wait_for(0);
    redirect_valid = 1;
    redirect_pc = 20'hFFFFF;
    wait_for(1);
    chk("t4_pc_top", 32'(instr_pc), 32'hFFFFF);
    wait_for(1);
    chk("t4_pc_wrap", 32'(instr_pc), 32'h00000);
    redirect_valid = 1;
    redirect_pc = 20'h12345;
    wait_for(1);
    chk("t5_pc", 32'(instr_pc), 32'h12345);
    ack_p = 60;
    rdy_p = 60;
    red_p = 8;
    repeat (3000) tick();
`ifdef URCPU_PERF_CNT_EN
    chk("perf_cnt", perf_fetch_cnt, 32'(hs_cnt));
`endif
    red_p = 0;
    ack_p = 0;
    wait_for(0);
    #2 rst = 1;
    #1;
    chk("arst_req_addr", 32'({imem_req, imem_addr}), 32'd0);
    chk("arst_valid", 32'(instr_valid), 32'd0);
    chk("arst_data_pc", 32'({instr_data, instr_pc}), 32'd0);
`ifdef URCPU_PERF_CNT_EN
    chk("arst_perf", perf_fetch_cnt, 32'd0);
`endif
    tick();
    tick();
    ack_p = 70;
    rdy_p = 70;
    red_p = 10;
    rst = 0;
    repeat (500) tick();
`ifdef URCPU_PERF_CNT_EN
    chk("perf_cnt_after_rst", perf_fetch_cnt, 32'(hs_cnt));
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
